// File: rtl/pl_pkg.sv
// Shared types for the pipeline hazard unit: forward-select codes, shadow entry, multiply FSM.
package pl_pkg;

    // Widest register address a shadow entry can hold; narrower REG_AW values are zero-extended.
    localparam int unsigned RN_W = 8;

    localparam int unsigned FW_REGFILE = 0;
    localparam int unsigned FW_EX      = 1;
    localparam int unsigned FW_MEM     = 2;
    localparam int unsigned FW_WB      = 3;

    typedef struct packed {
        logic            valid;
        logic            wreg;
        logic [RN_W-1:0] rn;
        logic            load;
    } shadow_entry_t;

    typedef enum logic {
        MulIdle = 1'b0,
        MulBusy = 1'b1
    } mul_state_e;

endpackage

// File: rtl/pl_fwd_sel.sv
// Priority match of one source register against the shadow pipeline (lowest stage wins).
module pl_fwd_sel
    import pl_pkg::*;
#(
    parameter int unsigned REG_AW         = 5,
    parameter int unsigned FWD_STAGES     = 3,
    parameter int unsigned LOAD_RDY_STAGE = 2,
    parameter int unsigned SEL_W          = $clog2(FWD_STAGES + 1)
) (
    input  logic [REG_AW-1:0]                 i_src,
    input  logic                              i_use,
    input  shadow_entry_t [FWD_STAGES-1:0]    i_stage,
    output logic [SEL_W-1:0]                  o_sel,
    output logic                              o_ld,
    output logic                              o_load_use
);

    logic w_found;

    always_comb begin
        o_sel      = SEL_W'(FW_REGFILE);
        o_ld       = 1'b0;
        o_load_use = 1'b0;
        w_found    = 1'b0;
        // Index i holds stage i+1 (0 = EX).
        for (int i = 0; i < int'(FWD_STAGES); i++) begin
            if (!w_found && i_use && i_stage[i].valid && i_stage[i].wreg &&
                (i_stage[i].rn != '0) && (i_stage[i].rn == RN_W'(i_src))) begin
                w_found = 1'b1;
                if (i_stage[i].load && ((i + 1) < int'(LOAD_RDY_STAGE))) begin
                    o_load_use = 1'b1;
                end else begin
                    o_sel = SEL_W'(i + 1);
                    o_ld  = i_stage[i].load;
                end
            end
        end
    end

endmodule

// File: rtl/pl_hazard_unit.sv
// Hazard detection and forwarding: shadow destination pipeline, load-use stall, multiply hold, flush.
// Optional HAZ_PERF_CNT_EN adds saturating stall-cycle and flush counters.
module pl_hazard_unit
    import pl_pkg::*;
#(
    parameter int unsigned REG_AW         = 5,
    parameter int unsigned FWD_STAGES     = 3,
    parameter int unsigned LOAD_RDY_STAGE = 2,
    parameter int unsigned MUL_LAT        = 4,
    parameter int unsigned SEL_W          = $clog2(FWD_STAGES + 1)
) (
    input  logic              i_clock,
    input  logic              i_resetn,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rt,
    input  logic              i_id_use_rs,
    input  logic              i_id_use_rt,
    input  logic              i_id_wreg,
    input  logic [REG_AW-1:0] i_id_rn,
    input  logic              i_id_load,
    input  logic              i_id_mul,
    input  logic              i_id_branch_taken,
    output logic              o_stall,
    output logic              o_bubble,
    output logic              o_flush_if,
    output logic [SEL_W-1:0]  o_fw_a,
    output logic [SEL_W-1:0]  o_fw_b,
    output logic              o_fw_a_ld,
    output logic              o_fw_b_ld
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]       o_stall_cycles,
    output logic [31:0]       o_flush_count
`endif
);

    localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    shadow_entry_t [FWD_STAGES-1:0] r_stage;
    shadow_entry_t [FWD_STAGES-1:0] w_stage_nxt;
    shadow_entry_t                  w_id_entry;
    mul_state_e                     r_mul_state;
    logic [CNT_W-1:0]               r_mul_cnt;

    logic w_busy;
    logic w_lu_a;
    logic w_lu_b;
    logic w_stall;
    logic w_flush;
    logic w_accept;

    pl_fwd_sel #(
        .REG_AW         (REG_AW),
        .FWD_STAGES     (FWD_STAGES),
        .LOAD_RDY_STAGE (LOAD_RDY_STAGE),
        .SEL_W          (SEL_W)
    ) u_fwd_a (
        .i_src      (i_id_rs),
        .i_use      (i_id_use_rs),
        .i_stage    (r_stage),
        .o_sel      (o_fw_a),
        .o_ld       (o_fw_a_ld),
        .o_load_use (w_lu_a)
    );

    pl_fwd_sel #(
        .REG_AW         (REG_AW),
        .FWD_STAGES     (FWD_STAGES),
        .LOAD_RDY_STAGE (LOAD_RDY_STAGE),
        .SEL_W          (SEL_W)
    ) u_fwd_b (
        .i_src      (i_id_rt),
        .i_use      (i_id_use_rt),
        .i_stage    (r_stage),
        .o_sel      (o_fw_b),
        .o_ld       (o_fw_b_ld),
        .o_load_use (w_lu_b)
    );

    assign w_busy     = (r_mul_state == MulBusy);
    assign w_stall    = w_busy | w_lu_a | w_lu_b;
    assign w_flush    = i_id_branch_taken & ~w_stall;
    assign w_accept   = i_id_valid & ~w_stall & ~w_flush;
    assign o_stall    = w_stall;
    assign o_bubble   = ~w_busy & (w_lu_a | w_lu_b);
    assign o_flush_if = w_flush;

    always_comb begin
        w_id_entry       = '0;
        w_id_entry.valid = 1'b1;
        w_id_entry.wreg  = i_id_wreg;
        w_id_entry.rn    = RN_W'(i_id_rn);
        w_id_entry.load  = i_id_load;
    end

    always_comb begin
        w_stage_nxt = '0;
        for (int i = 1; i < int'(FWD_STAGES); i++) begin
            w_stage_nxt[i] = r_stage[i-1];
        end
        // A busy multiply parks in EX and feeds empty slots into MEM behind it.
        if (w_busy) begin
            w_stage_nxt[0] = r_stage[0];
            w_stage_nxt[1] = '0;
        end else if (w_accept) begin
            w_stage_nxt[0] = w_id_entry;
        end
    end

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_stage <= '0;
        end else begin
            r_stage <= w_stage_nxt;
        end
    end

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_mul_state <= MulIdle;
            r_mul_cnt   <= '0;
        end else begin
            unique case (r_mul_state)
                MulIdle: begin
                    if (w_accept && i_id_mul && (MUL_LAT > 1)) begin
                        r_mul_cnt   <= CNT_W'(MUL_LAT - 1);
                        r_mul_state <= MulBusy;
                    end
                end
                MulBusy: begin
                    r_mul_cnt <= r_mul_cnt - 1'b1;
                    if (r_mul_cnt <= CNT_W'(1)) begin
                        r_mul_state <= MulIdle;
                    end
                end
                default: r_mul_state <= MulIdle;
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_flush && (r_flush_count != 32'hFFFF_FFFF)) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_pl_hazard_unit.sv
// Directed-vector bench for pl_hazard_unit with default parameters (3 stages, load ready at 2, MUL_LAT 4).
module tb_pl_hazard_unit;

    logic       clk = 1'b0;
    logic       resetn;
    logic       id_valid, id_use_rs, id_use_rt, id_wreg, id_load, id_mul, id_br;
    logic [4:0] id_rs, id_rt, id_rn;
    logic       stall, bubble, flush_if, fw_a_ld, fw_b_ld;
    logic [1:0] fw_a, fw_b;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pl_hazard_unit u_dut (
        .i_clock           (clk),
        .i_resetn          (resetn),
        .i_id_valid        (id_valid),
        .i_id_rs           (id_rs),
        .i_id_rt           (id_rt),
        .i_id_use_rs       (id_use_rs),
        .i_id_use_rt       (id_use_rt),
        .i_id_wreg         (id_wreg),
        .i_id_rn           (id_rn),
        .i_id_load         (id_load),
        .i_id_mul          (id_mul),
        .i_id_branch_taken (id_br),
        .o_stall           (stall),
        .o_bubble          (bubble),
        .o_flush_if        (flush_if),
        .o_fw_a            (fw_a),
        .o_fw_b            (fw_b),
        .o_fw_a_ld         (fw_a_ld),
        .o_fw_b_ld         (fw_b_ld)
`ifdef HAZ_PERF_CNT_EN
        ,
        .o_stall_cycles    (stall_cycles),
        .o_flush_count     (flush_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic st, input logic bu, input logic fl);
        check({tag, ".stall"},  32'(stall),    32'(st));
        check({tag, ".bubble"}, 32'(bubble),   32'(bu));
        check({tag, ".flush"},  32'(flush_if), 32'(fl));
    endtask

    task automatic check_fw(input string tag, input logic [1:0] a, input logic a_ld,
                            input logic [1:0] b, input logic b_ld);
        check({tag, ".fw_a"},    32'(fw_a),    32'(a));
        check({tag, ".fw_a_ld"}, 32'(fw_a_ld), 32'(a_ld));
        check({tag, ".fw_b"},    32'(fw_b),    32'(b));
        check({tag, ".fw_b_ld"}, 32'(fw_b_ld), 32'(b_ld));
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic wr,
                          input logic [4:0] rn, input logic ld, input logic mul, input logic br);
        id_valid = v;   id_rs = rs;     id_rt = rt;   id_use_rs = urs; id_use_rt = urt;
        id_wreg = wr;   id_rn = rn;     id_load = ld; id_mul = mul;    id_br = br;
    endtask

    task automatic idle_id();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle_id();
        repeat (3) next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        idle_id();
        #12;
        check_ctl("reset", 1'b0, 1'b0, 1'b0);
        check_fw("reset", 2'd0, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        next_cycle();

        // ALU back-to-back, then two producers matched at different stages.
        set_id(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0);   // add $1,$2,$3
        @(negedge clk); check_fw("alu0", 2'd0, 1'b0, 2'd0, 1'b0);
        next_cycle();
        set_id(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);   // add $4,$1,$5
        @(negedge clk);
        check_ctl("alu1", 1'b0, 1'b0, 1'b0);
        check_fw("alu1", 2'd1, 1'b0, 2'd0, 1'b0);
        next_cycle();
        drain();
        set_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0);   // add $1
        next_cycle();
        set_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);   // add $2
        next_cycle();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);   // add $4,$1,$2
        @(negedge clk); check_fw("mix", 2'd2, 1'b0, 2'd1, 1'b0);
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);   // rt not read
        #1; check_fw("use_rt0", 2'd2, 1'b0, 2'd0, 1'b0);
        next_cycle();
        drain();

        // Load-use: one stall with bubble, then forward load data from MEM.
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);   // lw $1,0($0)
        @(negedge clk); check_ctl("lw0", 1'b0, 1'b0, 1'b0);
        next_cycle();
        set_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);   // add $4,$1,$1
        @(negedge clk);
        check_ctl("lu1", 1'b1, 1'b1, 1'b0);
        check_fw("lu1", 2'd0, 1'b0, 2'd0, 1'b0);
        next_cycle();
        @(negedge clk);
        check_ctl("lu2", 1'b0, 1'b0, 1'b0);
        check_fw("lu2", 2'd2, 1'b1, 2'd2, 1'b1);
        next_cycle();
        drain();

        // Multiply: dependent add stalls exactly three cycles, then forwards from EX.
        set_id(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0);   // mul $1,$2,$3
        @(negedge clk); check_ctl("mul0", 1'b0, 1'b0, 1'b0);
        next_cycle();
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);   // add $4,$1,$0
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); check_ctl($sformatf("mulbusy%0d", i), 1'b1, 1'b0, 1'b0);
            next_cycle();
        end
        @(negedge clk);
        check_ctl("mulend", 1'b0, 1'b0, 1'b0);
        check_fw("mulend", 2'd1, 1'b0, 2'd0, 1'b0);
        next_cycle();
        drain();

        // Multiply followed by two empty slots: dependent forwards from WB.
        set_id(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0);
        next_cycle();
        idle_id();
        repeat (3) next_cycle();
        next_cycle();
        next_cycle();
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_ctl("mulgap", 1'b0, 1'b0, 1'b0);
        check_fw("mulgap", 2'd3, 1'b0, 2'd0, 1'b0);
        next_cycle();
        drain();

        // Writes to $0 (ALU in MEM, load in EX) never forward or stall.
        set_id(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        next_cycle();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_ctl("r0", 1'b0, 1'b0, 1'b0);
        check_fw("r0", 2'd0, 1'b0, 2'd0, 1'b0);
        next_cycle();
        drain();

        // Taken branch waiting on a load: stall without flush, then flush once.
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);   // lw $1
        next_cycle();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);   // beq $1,$2 taken
        @(negedge clk); check_ctl("br1", 1'b1, 1'b1, 1'b0);
        next_cycle();
        @(negedge clk);
        check_ctl("br2", 1'b0, 1'b0, 1'b1);
        check_fw("br2", 2'd1 + 2'd1, 1'b1, 2'd0, 1'b0);
        next_cycle();
        idle_id();
        @(negedge clk); check_ctl("br3", 1'b0, 1'b0, 1'b0);
        next_cycle();
        drain();

        // Asynchronous reset during the second busy cycle of a multiply.
        set_id(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0);
        next_cycle();
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
        next_cycle();
        check_ctl("prerst", 1'b1, 1'b0, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        check_ctl("rst", 1'b0, 1'b0, 1'b0);
        check_fw("rst", 2'd0, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        next_cycle();
        @(negedge clk);
        check_ctl("postrst", 1'b0, 1'b0, 1'b0);
        check_fw("postrst", 2'd0, 1'b0, 2'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
